// File: rtl/seven_segment_mux_driver.sv
// Time-multiplexed N-digit 7-segment driver: captures digit codes on load and
// scans them one digit at a time with one-hot anodes, registered outputs.
module seven_segment_mux_driver #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int HEX_MODE    = 0,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an
);

    localparam int   CW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int   IW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic INV = (ACTIVE_LOW != 0);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*N_DIGITS-1:0] held_dig_q, held_dig_d;
    logic [N_DIGITS-1:0]   held_dp_q, held_dp_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [N_DIGITS-1:0]   an_q, an_d;

    logic [3:0]            curCode;
    logic                  curDp;
    logic                  curBlank;
    logic                  zeroAbove;
    logic [6:0]            segLogical;
    logic [N_DIGITS-1:0]   anLogical;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            4'hA:    s = (HEX_MODE != 0) ? 7'b1110111 : 7'b0000000;
            4'hB:    s = (HEX_MODE != 0) ? 7'b0011111 : 7'b0000000;
            4'hC:    s = (HEX_MODE != 0) ? 7'b1001110 : 7'b0000000;
            4'hD:    s = (HEX_MODE != 0) ? 7'b0111101 : 7'b0000000;
            4'hE:    s = (HEX_MODE != 0) ? 7'b1001111 : 7'b0000000;
            default: s = (HEX_MODE != 0) ? 7'b1000111 : 7'b0000000;
        endcase
        return s;
    endfunction

    always_comb begin
        cnt_d      = cnt_q + CW'(1);
        idx_d      = idx_q;
        held_dig_d = load ? digits_in : held_dig_q;
        held_dp_d  = load ? dp_in : held_dp_q;
        if (cnt_q == CW'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    // Walk from the top digit down so zeroAbove covers digits i..N_DIGITS-1.
    always_comb begin
        zeroAbove = 1'b1;
        curCode   = 4'd0;
        curDp     = 1'b0;
        curBlank  = 1'b0;
        anLogical = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zeroAbove = zeroAbove && (held_dig_q[4*i +: 4] == 4'd0);
            if (idx_q == IW'(i)) begin
                curCode      = held_dig_q[4*i +: 4];
                curDp        = held_dp_q[i];
                curBlank     = blank_lz && (i != 0) && zeroAbove;
                anLogical[i] = !curBlank;
            end
        end
        segLogical = curBlank ? 7'b0000000 : decode(curCode);
        seg_d      = {7{INV}} ^ segLogical;
        dp_d       = INV ^ (curDp && !curBlank);
        an_d       = {N_DIGITS{INV}} ^ anLogical;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            held_dig_q <= '0;
            held_dp_q  <= '0;
            seg_q      <= {7{INV}};
            dp_q       <= INV;
            an_q       <= {N_DIGITS{INV}};
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            held_dig_q <= held_dig_d;
            held_dp_q  <= held_dp_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seven_segment_mux_driver.sv
// Bench for seven_segment_mux_driver: one hex/active-low and one BCD/active-high
// instance share stimulus; a table of frames plus hand-written timing sequences.
module tb_seven_segment_mux_driver;

    typedef struct packed {
        logic [15:0]      digits;
        logic [3:0]       dps;
        logic             blank;
        logic [3:0]       lit;
        logic [3:0][6:0]  segHex;
        logic [3:0][6:0]  segBcd;
    } vecT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digitsIn = '0;
    logic [3:0]  dpIn = '0;
    logic        load = 1'b0;
    logic        blankLz = 1'b0;
    logic [6:0]  segA, segB;
    logic        dpA, dpB;
    logic [3:0]  anA, anB;

    int checks = 0;
    int passes = 0;
    int edgeCount = 0;

    vecT vecs [7];
    vecT zeroRec;

    seven_segment_mux_driver #(.N_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(1), .ACTIVE_LOW(1)) dutA (
        .clk(clk), .reset(reset), .digits_in(digitsIn), .dp_in(dpIn), .load(load),
        .blank_lz(blankLz), .seg(segA), .dp(dpA), .an(anA)
    );

    seven_segment_mux_driver #(.N_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(0), .ACTIVE_LOW(0)) dutB (
        .clk(clk), .reset(reset), .digits_in(digitsIn), .dp_in(dpIn), .load(load),
        .blank_lz(blankLz), .seg(segB), .dp(dpB), .an(anB)
    );

    always #5 clk = ~clk;

    // Edges seen since reset was last released; drives the expected scan position.
    always @(posedge clk or posedge reset) begin
        if (reset) edgeCount <= 0;
        else       edgeCount <= edgeCount + 1;
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected)
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        else
            passes++;
    endtask

    task automatic checkCycle(input vecT v, input string tag);
        int d;
        logic [3:0] oneHot;
        logic [6:0] sh, sb;
        logic       l, p;
        d      = ((edgeCount - 1) / 4) % 4;
        oneHot = 4'b0001 << d;
        l      = v.lit[d];
        p      = l & v.dps[d];
        sh     = l ? v.segHex[d] : 7'b0000000;
        sb     = l ? v.segBcd[d] : 7'b0000000;
        checkOutput($sformatf("%s d%0d anA", tag, d), {4'b0, anA}, {4'b0, l ? ~oneHot : 4'hF});
        checkOutput($sformatf("%s d%0d segA", tag, d), {1'b0, segA}, {1'b0, ~sh});
        checkOutput($sformatf("%s d%0d dpA", tag, d), {7'b0, dpA}, {7'b0, ~p});
        checkOutput($sformatf("%s d%0d anB", tag, d), {4'b0, anB}, {4'b0, l ? oneHot : 4'h0});
        checkOutput($sformatf("%s d%0d segB", tag, d), {1'b0, segB}, {1'b0, sb});
        checkOutput($sformatf("%s d%0d dpB", tag, d), {7'b0, dpB}, {7'b0, p});
    endtask

    task automatic applyStimulus(input vecT v, input logic doLoad);
        digitsIn = v.digits;
        dpIn     = v.dps;
        blankLz  = v.blank;
        load     = doLoad;
    endtask

    task automatic checkInactive(input string tag);
        checkOutput({tag, " segA"}, {1'b0, segA}, 8'h7F);
        checkOutput({tag, " dpA"}, {7'b0, dpA}, 8'h01);
        checkOutput({tag, " anA"}, {4'b0, anA}, 8'h0F);
        checkOutput({tag, " segB"}, {1'b0, segB}, 8'h00);
        checkOutput({tag, " dpB"}, {7'b0, dpB}, 8'h00);
        checkOutput({tag, " anB"}, {4'b0, anB}, 8'h00);
    endtask

    task automatic waitPhase(input int modulus, input int value);
        for (int k = 0; k < 64 && (edgeCount % modulus) != value; k++) @(negedge clk);
        if ((edgeCount % modulus) != value) begin
            checks++;
            $display("[TB] FAIL phase wait timeout actual=%0d expected=%0d", edgeCount % modulus, value);
        end
    endtask

    initial begin
        zeroRec = '{16'h0000, 4'b0000, 1'b0, 4'b1111,
                    {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110},
                    {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}};
        vecs[0] = '{16'h1234, 4'b0100, 1'b0, 4'b1111,
                    {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011},
                    {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}};
        vecs[1] = '{16'h0070, 4'b0000, 1'b1, 4'b0011,
                    {7'b1111110, 7'b1111110, 7'b1110000, 7'b1111110},
                    {7'b1111110, 7'b1111110, 7'b1110000, 7'b1111110}};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, 4'b0001,
                    {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110},
                    {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}};
        vecs[3] = '{16'h00AF, 4'b1001, 1'b0, 4'b1111,
                    {7'b1111110, 7'b1111110, 7'b1110111, 7'b1000111},
                    {7'b1111110, 7'b1111110, 7'b0000000, 7'b0000000}};
        vecs[4] = '{16'hA000, 4'b0000, 1'b1, 4'b1111,
                    {7'b1110111, 7'b1111110, 7'b1111110, 7'b1111110},
                    {7'b0000000, 7'b1111110, 7'b1111110, 7'b1111110}};
        vecs[5] = '{16'h0900, 4'b1111, 1'b1, 4'b0111,
                    {7'b0000000, 7'b1111011, 7'b1111110, 7'b1111110},
                    {7'b0000000, 7'b1111011, 7'b1111110, 7'b1111110}};
        vecs[6] = '{16'h8765, 4'b0010, 1'b1, 4'b1111,
                    {7'b1111111, 7'b1110000, 7'b1011111, 7'b1011011},
                    {7'b1111111, 7'b1110000, 7'b1011111, 7'b1011011}};

        // Reset held for three cycles, then digit 0 shows "0" for a full dwell.
        repeat (3) @(negedge clk);
        checkInactive("reset");
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkCycle(zeroRec, "postreset");
        end

        // Table of loaded frames, each checked over a full 16-cycle frame.
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            applyStimulus(vecs[v], 1'b1);
            @(negedge clk);
            load = 1'b0;
            repeat (2) @(negedge clk);
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                checkCycle(vecs[v], $sformatf("vec%0d", v));
            end
        end

        // New inputs without load must not reach the display.
        digitsIn = 16'h1111;
        dpIn     = 4'hF;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            checkCycle(vecs[6], "noload");
        end

        // Load pulsed mid-dwell: old value at edge t, new value at edge t+1.
        waitPhase(4, 2);
        applyStimulus(vecs[0], 1'b1);
        @(negedge clk);
        load = 1'b0;
        checkCycle(vecs[6], "latency old");
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkCycle(vecs[0], "latency new");
        end

        // Asynchronous reset at idx=2, cnt=1, observed before any clock edge.
        blankLz = 1'b0;
        waitPhase(16, 9);
        #2 reset = 1'b1;
        #1 checkInactive("asyncreset");
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkCycle(zeroRec, "afterasync");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
